// File: rtl/cache_trace_buf_if.sv
// Main-memory request bus as seen by the trace buffer: one transaction beat per valid cycle.
// The cache side drives the master modport; the trace buffer only observes through slave.
interface cache_trace_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mm_valid;
    logic              mm_write;
    logic [ADDR_W-1:0] mm_addr;
    logic [DATA_W-1:0] mm_data;

    modport master (output mm_valid, mm_write, mm_addr, mm_data);
    modport slave  (input  mm_valid, mm_write, mm_addr, mm_data);
endinterface

// File: rtl/cache_trace_buf.sv
// DEPTH-entry capture buffer for main-memory beats: fill-once or circular with trigger + post count.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running cycle stamp per entry and the rd_ts_o port.
module cache_trace_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    cache_trace_buf_if.slave    mm,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic                mode_i,
    input  logic                trig_i,
    input  logic [PTR_W:0]      post_len_i,
    input  logic [PTR_W-1:0]    rd_idx_i,
    output logic [ADDR_W-1:0]   rd_addr_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_wr_o,
    output logic [1:0]          state_o,
    output logic [PTR_W:0]      count_o,
    output logic                wrapped_o,
    output logic [CNT_W-1:0]    wr_cnt_o,
    output logic [CNT_W-1:0]    rd_cnt_o
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]         rd_ts_o
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, POST = 2'd2, DONE = 2'd3} state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0]       ts;
`endif
    } entry_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LAST_CNT = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W:0]    count_q;
    logic              wrapped_q;
    logic              mode_q;
    logic [PTR_W:0]    post_len_q;
    logic [PTR_W:0]    post_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    entry_t            rd_q;
    entry_t            wr_entry;
    entry_t            ram [DEPTH];

    logic              cap_en;
    logic              load_post;
    logic              clear;
    logic [PTR_W-1:0]  phys;
    logic              in_range;

    // FSM state register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: abort beats arm, arm beats trigger, trigger beats plain capture
    // NOTE: state_d gets a default before any branch so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else if (arm_i) begin
            state_d = CAPTURE;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (mode_q && trig_i)
                        state_d = (post_len_q == '0) ? DONE : POST;
                    else if (!mode_q && mm.mm_valid && count_q == LAST_CNT)
                        state_d = DONE;
                end
                POST:    if (mm.mm_valid && post_cnt_q == (PTR_W+1)'(1)) state_d = DONE;
                default: ;
            endcase
        end
    end

    // FSM outputs: datapath strobes
    always_comb begin
        clear     = arm_i && !abort_i;
        cap_en    = mm.mm_valid && !abort_i && !arm_i && (state_q == CAPTURE || state_q == POST);
        load_post = !abort_i && !arm_i && state_q == CAPTURE && mode_q && trig_i;
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 32'd1;
    end
`endif

    always_comb begin
        wr_entry      = '0;
        wr_entry.wr   = mm.mm_write;
        wr_entry.addr = mm.mm_addr;
        wr_entry.data = mm.mm_data;
`ifdef TRACE_TIMESTAMP_EN
        wr_entry.ts   = ts_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            mode_q     <= 1'b0;
            post_len_q <= '0;
            post_cnt_q <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else if (clear) begin
            wptr_q     <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            mode_q     <= mode_i;
            post_len_q <= post_len_i;
            post_cnt_q <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            if (cap_en) begin
                wptr_q <= wptr_q + PTR_W'(1);
                if (wptr_q == LAST_PTR) wrapped_q <= 1'b1;
                if (count_q != FULL_CNT) count_q <= count_q + (PTR_W+1)'(1);
                if (mm.mm_write && wr_cnt_q != '1)  wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                if (!mm.mm_write && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
            if (load_post)
                post_cnt_q <= post_len_q;
            else if (cap_en && state_q == POST)
                post_cnt_q <= post_cnt_q - (PTR_W+1)'(1);
        end
    end

    // NOTE: the RAM array has no reset; only count/wrapped decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (cap_en) ram[wptr_q] <= wr_entry;
    end

    // Logical index 0 is the oldest entry; once wrapped, that sits at the write pointer.
    assign phys     = wrapped_q ? wptr_q + rd_idx_i : rd_idx_i;
    assign in_range = {1'b0, rd_idx_i} < count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         rd_q <= '0;
        else if (in_range) rd_q <= ram[phys];
        else               rd_q <= '0;
    end

    assign rd_addr_o = rd_q.addr;
    assign rd_data_o = rd_q.data;
    assign rd_wr_o   = rd_q.wr;
`ifdef TRACE_TIMESTAMP_EN
    assign rd_ts_o   = rd_q.ts;
`endif
    assign state_o   = state_q;
    assign count_o   = count_q;
    assign wrapped_o = wrapped_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign rd_cnt_o  = rd_cnt_q;

endmodule

// File: tb/tb_cache_trace_buf.sv
// Self-checking bench for cache_trace_buf: readback expectations go through a scoreboard queue.
// Define TRACE_TIMESTAMP_EN for both RTL and bench to exercise the timestamp scenario.
module tb_cache_trace_buf;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;
    localparam int CNT_W  = 16;

    localparam logic [1:0] S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_POST = 2'd2, S_DONE = 2'd3;

    logic clk = 1'b0;
    logic reset;
    logic arm, abort, mode, trig;
    logic [PTR_W:0]    post_len;
    logic [PTR_W-1:0]  rd_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_wr;
    logic [1:0]        state;
    logic [PTR_W:0]    count;
    logic              wrapped;
    logic [CNT_W-1:0]  wr_cnt, rd_cnt;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       rd_ts;
`endif

    always #5 clk = ~clk;

    cache_trace_buf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mm_if ();

    cache_trace_buf #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .mm(mm_if),
        .arm_i(arm), .abort_i(abort), .mode_i(mode), .trig_i(trig),
        .post_len_i(post_len), .rd_idx_i(rd_idx),
        .rd_addr_o(rd_addr), .rd_data_o(rd_data), .rd_wr_o(rd_wr),
        .state_o(state), .count_o(count), .wrapped_o(wrapped),
        .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
`ifdef TRACE_TIMESTAMP_EN
        , .rd_ts_o(rd_ts)
`endif
    );

    typedef struct {
        string             tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too, half a cycle after the DUT edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_arm(input logic m, input logic [PTR_W:0] pl, input logic t);
        arm = 1'b1; mode = m; post_len = pl; trig = t;
        tick();
        arm = 1'b0; trig = 1'b0;
    endtask

    task automatic beat(input logic w, input logic [31:0] a, input logic [31:0] d, input logic t);
        mm_if.mm_valid = 1'b1; mm_if.mm_write = w; mm_if.mm_addr = a; mm_if.mm_data = d; trig = t;
        tick();
        mm_if.mm_valid = 1'b0; trig = 1'b0;
    endtask

    task automatic readback(input string tag, input logic [PTR_W-1:0] idx,
                            input logic [31:0] ea, input logic [31:0] ed, input logic ew);
        exp_t e;
        e.tag = tag; e.addr = ea; e.data = ed; e.wr = ew;
        rd_idx = idx;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check({e.tag, ".addr"}, rd_addr, e.addr);
        check({e.tag, ".data"}, rd_data, e.data);
        check({e.tag, ".wr"},   rd_wr,   e.wr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; arm = 0; abort = 0; mode = 0; trig = 0; post_len = '0; rd_idx = '0;
        mm_if.mm_valid = 0; mm_if.mm_write = 0; mm_if.mm_addr = '0; mm_if.mm_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst.state", state, S_IDLE);
        check("rst.count", count, 0);
        check("rst.wrapped", wrapped, 0);
        check("rst.wr_cnt", wr_cnt, 0);
        check("rst.rd_addr", rd_addr, 0);

        // Beat while idle is not captured
        beat(1'b1, 32'h0, 32'h0, 1'b0);
        check("idle.count", count, 0);

        // 1: fill-once
        do_arm(1'b0, '0, 1'b0);
        check("t1.armed", state, S_CAPTURE);
        for (int i = 0; i < 20; i++) begin
            beat(1'b1, 32'h100 + 4 * i, i, 1'b0);
            if (i == 14) check("t1.state15", state, S_CAPTURE);
            if (i == 15) check("t1.state16", state, S_DONE);
        end
        check("t1.count", count, 16);
        check("t1.wr_cnt", wr_cnt, 16);
        check("t1.rd_cnt", rd_cnt, 0);
        readback("t1.idx15", 4'd15, 32'h13C, 32'd15, 1'b1);
        readback("t1.idx0",  4'd0,  32'h100, 32'd0,  1'b1);

        // 2: circular, trigger on beat 17, three post beats
        do_arm(1'b1, 5'd3, 1'b0);
        for (int i = 0; i < 21; i++) begin
            beat(1'b0, i, 32'h1000 + i, i == 17);
            if (i == 17) check("t2.post", state, S_POST);
            if (i == 19) check("t2.post19", state, S_POST);
            if (i == 20) check("t2.done", state, S_DONE);
        end
        check("t2.wrapped", wrapped, 1);
        check("t2.count", count, 16);
        check("t2.rd_cnt", rd_cnt, 21);
        check("t2.wr_cnt", wr_cnt, 0);
        readback("t2.idx0",  4'd0,  32'd5,  32'h1005, 1'b0);
        readback("t2.idx15", 4'd15, 32'd20, 32'h1014, 1'b0);

        // 3: post_len zero finishes on the trigger beat
        do_arm(1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) beat(1'b1, 32'h200 + i, 32'h2000 + i, i == 2);
        check("t3.done", state, S_DONE);
        check("t3.count", count, 3);
        check("t3.wrapped", wrapped, 0);
        readback("t3.idx3", 4'd3, 32'h0, 32'h0, 1'b0);
        readback("t3.idx2", 4'd2, 32'h202, 32'h2002, 1'b1);

        // 4: abort during POST keeps contents; arm wins over a simultaneous trigger
        do_arm(1'b1, 5'd8, 1'b0);
        for (int i = 0; i < 5; i++) beat(1'b1, 32'h400 + i, 32'h4000 + i, i == 1);
        check("t4.post", state, S_POST);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t4.idle", state, S_IDLE);
        check("t4.count", count, 5);
        beat(1'b1, 32'hDEAD, 32'hBEEF, 1'b0);
        check("t4.count_hold", count, 5);
        check("t4.wr_cnt_hold", wr_cnt, 5);
        readback("t4.idx4", 4'd4, 32'h404, 32'h4004, 1'b1);
        do_arm(1'b1, 5'd8, 1'b1);
        check("t4.arm_trig", state, S_CAPTURE);
        check("t4.arm_count", count, 0);
        tick();
        check("t4.still_cap", state, S_CAPTURE);

        // 5: asynchronous reset in the middle of a cycle
        beat(1'b1, 32'h500, 32'h5000, 1'b0);
        beat(1'b1, 32'h504, 32'h5004, 1'b0);
        readback("t5.idx0", 4'd0, 32'h500, 32'h5000, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("t5.state", state, S_IDLE);
        check("t5.count", count, 0);
        check("t5.wr_cnt", wr_cnt, 0);
        check("t5.rd_addr", rd_addr, 0);
        check("t5.rd_data", rd_data, 0);
        @(negedge clk);
        reset = 1'b0;
        beat(1'b1, 32'h508, 32'h5008, 1'b0);
        check("t5.no_cap", count, 0);
        check("t5.no_cap_state", state, S_IDLE);

`ifdef TRACE_TIMESTAMP_EN
        // 6: beats three cycles apart carry stamps three apart
        begin
            logic [31:0] ts0;
            do_arm(1'b0, '0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                beat(1'b1, 32'h600 + i, i, 1'b0);
                tick(); tick();
            end
            rd_idx = 4'd0; tick(); ts0 = rd_ts;
            rd_idx = 4'd1; tick();
            check("t6.delta01", rd_ts - ts0, 3);
            ts0 = rd_ts;
            rd_idx = 4'd2; tick();
            check("t6.delta12", rd_ts - ts0, 3);
            rd_idx = 4'd3; tick();
            check("t6.beyond", rd_ts, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
